// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the external SRAM access arbiter.
package sram_arb_pkg;

  localparam int ADDRW_DEF  = 19;
  localparam int DATAW_DEF  = 128;
  localparam int RD_LAT_DEF = 2;
  localparam int TURN_DEF   = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_TURN,
    ST_WR_SETUP,
    ST_WR_PULSE,
    ST_WR_HOLD,
    ST_RD_WAIT
  } state_t;

  localparam logic DIR_READ  = 1'b0;
  localparam logic DIR_WRITE = 1'b1;

endpackage

// File: rtl/sram_arb_rr.sv
// Two-requester round-robin grant; the last-grant register moves only on an accepted grant.
module sram_arb_rr
  import sram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic req_wr,
  input  logic req_rd,
  output logic gnt_wr,
  output logic gnt_rd
);

  logic last_gnt;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    gnt_wr = 1'b0;
    gnt_rd = 1'b0;
    if (en) begin
      if (req_wr && req_rd) begin
        gnt_wr = (last_gnt == DIR_READ);
        gnt_rd = (last_gnt == DIR_WRITE);
      end else begin
        gnt_wr = req_wr;
        gnt_rd = req_rd;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= DIR_READ;
    end else if (gnt_wr) begin
      last_gnt <= DIR_WRITE;
    end else if (gnt_rd) begin
      last_gnt <= DIR_READ;
    end
  end

endmodule

// File: rtl/sram_access_arb.sv
// Arbitrates and sequences the shared 4-bank SRAM between the init write stream and the lookup reads.
// Optional macro SRAM_ARB_STATS_EN adds saturating stat_wr/stat_rd/stat_stall counters.
module sram_access_arb
  import sram_arb_pkg::*;
#(
  parameter int ADDRW  = ADDRW_DEF,
  parameter int DATAW  = DATAW_DEF,
  parameter int RD_LAT = RD_LAT_DEF,
  parameter int TURN   = TURN_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [ADDRW-1:0] wr_addr,
  input  logic [DATAW-1:0] wr_data,
  input  logic             rd_valid,
  output logic             rd_ready,
  input  logic [ADDRW-1:0] rd_addr,
  output logic             rsp_valid,
  output logic [DATAW-1:0] rsp_data,
  output logic             mode_R1_W0,
  output logic [ADDRW-1:0] SRAM_ADDR_Pin,
  output logic [DATAW-1:0] SRAM_DATA_IN_Pin,
  input  logic [DATAW-1:0] SRAM_DATA_OUT_Pin,
  output logic             SRAM_CS_n,
  output logic             SRAM_WR_n,
  output logic             SRAM_OE_n
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [15:0]      stat_wr,
  output logic [15:0]      stat_rd,
  output logic [15:0]      stat_stall
`endif
);

  localparam bit         HAS_TURN  = (TURN > 0);
  localparam logic [3:0] TURN_M1   = HAS_TURN ? 4'(TURN - 1) : 4'd0;
  localparam logic [3:0] RD_LAT_M1 = 4'(RD_LAT - 1);

  state_t     state;
  logic       last_dir;
  logic       pend_dir;
  logic [3:0] cnt;
  logic       gnt_wr, gnt_rd, accept, acc_dir, need_turn;
  logic       launch, launch_dir;

  sram_arb_rr u_rr (
    .clk    (CLK),
    .rst    (RST),
    .en     ((state == ST_IDLE) && !RST),
    .req_wr (wr_valid),
    .req_rd (rd_valid),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

  assign wr_ready  = gnt_wr;
  assign rd_ready  = gnt_rd;
  assign accept    = gnt_wr | gnt_rd;
  assign acc_dir   = gnt_wr ? DIR_WRITE : DIR_READ;
  assign need_turn = HAS_TURN && (acc_dir != last_dir);

  // A transfer starts its strobe sequence either straight from IDLE or when the turnaround expires.
  always_comb begin
    launch     = 1'b0;
    launch_dir = pend_dir;
    if (state == ST_IDLE && accept && !need_turn) begin
      launch     = 1'b1;
      launch_dir = acc_dir;
    end else if (state == ST_TURN && cnt == 4'd0) begin
      launch = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state            <= ST_IDLE;
      last_dir         <= DIR_READ;
      pend_dir         <= DIR_READ;
      cnt              <= 4'd0;
      SRAM_CS_n        <= 1'b1;
      SRAM_WR_n        <= 1'b1;
      SRAM_OE_n        <= 1'b1;
      mode_R1_W0       <= 1'b1;
      SRAM_ADDR_Pin    <= '0;
      SRAM_DATA_IN_Pin <= '0;
      rsp_data         <= '0;
      rsp_valid        <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            SRAM_ADDR_Pin <= gnt_wr ? wr_addr : rd_addr;
            if (gnt_wr) SRAM_DATA_IN_Pin <= wr_data;
            pend_dir <= acc_dir;
            if (need_turn) begin
              state <= ST_TURN;
              cnt   <= TURN_M1;
            end
          end
        end
        ST_TURN: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
        end
        ST_WR_SETUP: begin
          SRAM_WR_n <= 1'b0;
          state     <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          SRAM_WR_n <= 1'b1;
          state     <= ST_WR_HOLD;
        end
        ST_WR_HOLD: begin
          SRAM_CS_n  <= 1'b1;
          mode_R1_W0 <= 1'b1;
          last_dir   <= DIR_WRITE;
          state      <= ST_IDLE;
        end
        ST_RD_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_data  <= SRAM_DATA_OUT_Pin;
            rsp_valid <= 1'b1;
            SRAM_CS_n <= 1'b1;
            SRAM_OE_n <= 1'b1;
            last_dir  <= DIR_READ;
            state     <= ST_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (launch) begin
        SRAM_CS_n <= 1'b0;
        if (launch_dir == DIR_WRITE) begin
          mode_R1_W0 <= 1'b0;
          state      <= ST_WR_SETUP;
        end else begin
          SRAM_OE_n <= 1'b0;
          cnt       <= RD_LAT_M1;
          state     <= ST_RD_WAIT;
        end
      end
    end
  end

`ifdef SRAM_ARB_STATS_EN
  logic stall;
  assign stall = (wr_valid && !wr_ready) || (rd_valid && !rd_ready);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_wr    <= 16'd0;
      stat_rd    <= 16'd0;
      stat_stall <= 16'd0;
    end else begin
      if (gnt_wr && stat_wr != 16'hFFFF) stat_wr <= stat_wr + 16'd1;
      if (gnt_rd && stat_rd != 16'hFFFF) stat_rd <= stat_rd + 16'd1;
      if (stall && stat_stall != 16'hFFFF) stat_stall <= stat_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sram_access_arb.sv
// Directed bench for sram_access_arb: default instance (RD_LAT=2, TURN=1) plus a TURN=0, RD_LAT=3 instance.
module tb_sram_access_arb;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic          wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, mode;
  logic [18:0]   wr_addr, rd_addr, sram_addr;
  logic [127:0]  wr_data, rsp_data, sram_din, sram_dout;
  logic          cs_n, we_n, oe_n;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]   stat_wr, stat_rd, stat_stall;
`endif

  sram_access_arb dut (
    .CLK(clk), .RST(rst),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .mode_R1_W0(mode),
    .SRAM_ADDR_Pin(sram_addr), .SRAM_DATA_IN_Pin(sram_din), .SRAM_DATA_OUT_Pin(sram_dout),
    .SRAM_CS_n(cs_n), .SRAM_WR_n(we_n), .SRAM_OE_n(oe_n)
`ifdef SRAM_ARB_STATS_EN
    , .stat_wr(stat_wr), .stat_rd(stat_rd), .stat_stall(stat_stall)
`endif
  );

  // Small SRAM model indexed by the low address nibble
  logic [127:0] mem [16];
  always @(posedge clk) if (!cs_n && !we_n) mem[sram_addr[3:0]] <= sram_din;
  assign sram_dout = mem[sram_addr[3:0]];

  // TURN=0, RD_LAT=3 instance with an address-derived read model
  logic          b_wr_ready, b_rd_valid, b_rd_ready, b_rsp_valid, b_mode;
  logic [18:0]   b_rd_addr, b_sram_addr;
  logic [127:0]  b_rsp_data, b_sram_din, b_sram_dout;
  logic          b_cs_n, b_we_n, b_oe_n;
`ifdef SRAM_ARB_STATS_EN
  logic [15:0]   b_stat_wr, b_stat_rd, b_stat_stall;
`endif

  function automatic logic [127:0] b_model(input logic [18:0] a);
    return {4{32'hA5A5_0000}} ^ {109'd0, a};
  endfunction
  assign b_sram_dout = b_model(b_sram_addr);

  sram_access_arb #(.RD_LAT(3), .TURN(0)) dut_b (
    .CLK(clk), .RST(rst),
    .wr_valid(1'b0), .wr_ready(b_wr_ready), .wr_addr(19'd0), .wr_data(128'd0),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_addr(b_rd_addr),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .mode_R1_W0(b_mode),
    .SRAM_ADDR_Pin(b_sram_addr), .SRAM_DATA_IN_Pin(b_sram_din), .SRAM_DATA_OUT_Pin(b_sram_dout),
    .SRAM_CS_n(b_cs_n), .SRAM_WR_n(b_we_n), .SRAM_OE_n(b_oe_n)
`ifdef SRAM_ARB_STATS_EN
    , .stat_wr(b_stat_wr), .stat_rd(b_stat_rd), .stat_stall(b_stat_stall)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] pins();
    return {cs_n, we_n, oe_n, mode};
  endfunction

  localparam logic [3:0] P_IDLE  = 4'b1111;
  localparam logic [3:0] P_WSET  = 4'b0110;
  localparam logic [3:0] P_WPUL  = 4'b0010;
  localparam logic [3:0] P_RWAIT = 4'b0101;

  task automatic do_write(input logic [18:0] a, input logic [127:0] d, input logic turn_exp);
    cyc();
    wr_addr = a; wr_data = d; wr_valid = 1'b1;
    @(negedge clk);
    check("wr_ready_at_T", wr_ready, 1'b1);
    check("rd_ready_quiet", rd_ready, 1'b0);
    cyc();
    wr_valid = 1'b0;
    if (turn_exp) begin
      @(negedge clk);
      check("wr_turn_pins", pins(), P_IDLE);
      cyc();
    end
    @(negedge clk);
    check("wr_setup_pins", pins(), P_WSET);
    check("wr_addr_pin", sram_addr, a);
    check("wr_data_pin", sram_din, d);
    cyc();
    @(negedge clk);
    check("wr_pulse_pins", pins(), P_WPUL);
    cyc();
    @(negedge clk);
    check("wr_hold_pins", pins(), P_WSET);
    check("wr_hold_data", sram_din, d);
    cyc();
    @(negedge clk);
    check("wr_done_pins", pins(), P_IDLE);
  endtask

  task automatic do_read(input logic [18:0] a, input logic [127:0] d, input logic turn_exp);
    cyc();
    rd_addr = a; rd_valid = 1'b1;
    @(negedge clk);
    check("rd_ready_at_T", rd_ready, 1'b1);
    check("wr_ready_quiet", wr_ready, 1'b0);
    cyc();
    rd_valid = 1'b0;
    if (turn_exp) begin
      @(negedge clk);
      check("rd_turn_pins", pins(), P_IDLE);
      cyc();
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("rd_wait_pins", pins(), P_RWAIT);
      check("rd_no_early_rsp", rsp_valid, 1'b0);
      cyc();
    end
    @(negedge clk);
    check("rd_rsp_valid", rsp_valid, 1'b1);
    check("rd_rsp_data", rsp_data, d);
    check("rd_done_pins", pins(), P_IDLE);
    cyc();
    @(negedge clk);
    check("rd_rsp_pulse_end", rsp_valid, 1'b0);
  endtask

  localparam logic [127:0] WORD0 = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
  localparam logic [127:0] WORD1 = 128'h11112222_33334444_55556666_77778888;

  // {wr_ready, rd_ready, rsp_valid, CS_n, WR_n, OE_n, mode} while both requesters stay valid
  logic [6:0] contend_exp [20] = '{
    7'b100_1111, 7'b000_1111, 7'b000_0110, 7'b000_0010, 7'b000_0110,
    7'b010_1111, 7'b000_1111, 7'b000_0101, 7'b000_0101, 7'b101_1111,
    7'b000_1111, 7'b000_0110, 7'b000_0010, 7'b000_0110, 7'b010_1111,
    7'b000_1111, 7'b000_0101, 7'b000_0101, 7'b101_1111, 7'b000_1111
  };

  // {rd_ready, rsp_valid, CS_n, OE_n} for back-to-back reads on the TURN=0 instance
  logic [3:0] b2b_exp [13] = '{
    4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b0000, 4'b0000,
    4'b0000, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0111
  };
  logic [18:0] b_addrs [3] = '{19'h00010, 19'h00020, 19'h00030};

  initial begin
    rst = 1'b1;
    wr_valid = 1'b0; rd_valid = 1'b0; wr_addr = '0; rd_addr = '0; wr_data = '0;
    b_rd_valid = 1'b0; b_rd_addr = '0;
    repeat (2) @(negedge clk);
    check("rst_pins", pins(), P_IDLE);
    check("rst_addr", sram_addr, 19'd0);
    check("rst_din", sram_din, 128'd0);
    check("rst_rsp", {rsp_valid, rsp_data}, 129'd0);
    check("rst_ready", {wr_ready, rd_ready}, 2'b00);
    cyc();
    rst = 1'b0;

    // Single write then read-back, both crossing a turnaround
    do_write(19'h00123, WORD0, 1'b1);
    do_read(19'h00123, WORD0, 1'b1);

    // Both requesters held: grants alternate with one turnaround per direction change
    cyc();
    wr_addr = 19'h00005; wr_data = WORD1; wr_valid = 1'b1;
    rd_addr = 19'h00123; rd_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("contend_c%0d", i),
            {wr_ready, rd_ready, rsp_valid, cs_n, we_n, oe_n, mode}, contend_exp[i]);
      cyc();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (4) cyc();

    // Back-to-back reads with no turnaround and RD_LAT=3
    begin
      int nacc = 0;
      int nrsp = 0;
      b_rd_addr = b_addrs[0]; b_rd_valid = 1'b1;
      for (int i = 0; i < 13; i++) begin
        @(negedge clk);
        check($sformatf("b2b_c%0d", i), {b_rd_ready, b_rsp_valid, b_cs_n, b_oe_n}, b2b_exp[i]);
        if (b_rsp_valid) begin
          check($sformatf("b2b_data%0d", nrsp), b_rsp_data, b_model(b_addrs[nrsp]));
          nrsp++;
        end
        if (b_rd_ready) nacc++;
        cyc();
        if (nacc < 3) b_rd_addr = b_addrs[nacc];
        else b_rd_valid = 1'b0;
      end
    end

    // Reset during WR_PULSE drops the write immediately
    wr_addr = 19'h00007; wr_data = WORD1; wr_valid = 1'b1;
    @(negedge clk);
    check("abort_wr_ready", wr_ready, 1'b1);
    cyc();
    wr_valid = 1'b0;
    @(negedge clk);
    check("abort_setup", pins(), P_WSET);
    cyc();
    @(negedge clk);
    check("abort_pulse", pins(), P_WPUL);
    #1 rst = 1'b1;
    #1 check("abort_strobes_high", pins(), P_IDLE);
    cyc();
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_no_rsp", {rsp_valid, pins()}, {1'b0, P_IDLE});
      cyc();
    end
    do_write(19'h00009, WORD0, 1'b1);
`ifdef SRAM_ARB_STATS_EN
    check("stat_wr_after_rst", stat_wr, 16'd1);
    check("stat_rd_after_rst", stat_rd, 16'd0);
    check("stat_stall_after_rst", stat_stall, 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sram_access_arb.md
Name: sram_access_arb

Overview:
- Arbitrates and sequences the shared 4-bank external SRAM (one 128-bit bus, one 19-bit address) between two requesters: the init write stream and the primitive-check lookup read port.
- Owns all SRAM pin timing (CS/WR/OE strobes, data-bus direction, read latency, bus turnaround) and drives the read/write mode line consumed by the tristate at top level.
- Sits between the init loader / lookup logic and the per-bank SRAM pin drivers.

Parameters:
- ADDRW, 19, SRAM address width.
- DATAW, 128, data width (4 banks x 32).
- RD_LAT, 2, cycles CS_n/OE_n are held before read data is sampled (1..15).
- TURN, 1, idle cycles inserted when the bus switches direction (0..7; 0 means no turnaround).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous reset, active-high.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted this cycle (transfer = wr_valid & wr_ready).
- wr_addr  in  ADDRW  write address.
- wr_data  in  DATAW  write data.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted this cycle.
- rd_addr  in  ADDRW  read address.
- rsp_valid  out  1  one-cycle pulse; rsp_data is valid.
- rsp_data  out  DATAW  read data, held until the next response.
- mode_R1_W0  out  1  1 = bus released/read, 0 = arbiter drives bus.
- SRAM_ADDR_Pin  out  ADDRW  address to SRAM.
- SRAM_DATA_IN_Pin  out  DATAW  data driven into SRAM.
- SRAM_DATA_OUT_Pin  in  DATAW  data returned from SRAM.
- SRAM_CS_n  out  1  chip select, active-low.
- SRAM_WR_n  out  1  write strobe, active-low.
- SRAM_OE_n  out  1  output enable, active-low.

Behaviour:
- Reset (async, immediate): state IDLE; CS_n/WR_n/OE_n = 1; mode_R1_W0 = 1; address, data and rsp_data = 0; rsp_valid/wr_ready/rd_ready = 0; last_dir = READ; round-robin pointer favours write.
- Reset asserted mid-operation: strobes deassert in the same cycle, the in-flight transaction is dropped and no rsp_valid is issued.
- States: IDLE, TURN, WR_SETUP, WR_PULSE, WR_HOLD, RD_WAIT.
- IDLE arbitration: 2-way round-robin.
  - A single requester is granted.
  - If both request, the winner is the requester not granted last.
  - wr_ready/rd_ready are combinational from IDLE & grant. Only one is high in any cycle.
- On accept: address and data are registered.
  - If the granted direction differs from last_dir and TURN > 0, go to TURN.
  - Otherwise go directly to WR_SETUP or RD_WAIT.
- TURN: all strobes high, mode_R1_W0 = 1, lasts exactly TURN cycles.
- Write sequence, one cycle per state, mode_R1_W0 = 0 throughout, data driven from WR_SETUP to WR_HOLD:
  - WR_SETUP: CS_n = 0, WR_n = 1.
  - WR_PULSE: CS_n = 0, WR_n = 0.
  - WR_HOLD: CS_n = 0, WR_n = 1.
  - Then IDLE; last_dir = WRITE.
- RD_WAIT: CS_n = 0, OE_n = 0, mode_R1_W0 = 1 for RD_LAT cycles.
  - SRAM_DATA_OUT_Pin is captured at the end of the last RD_WAIT cycle.
  - rsp_valid pulses the following cycle; return to IDLE; last_dir = READ.
- No accept while not in IDLE. Same-direction back-to-back throughput: write every 4 cycles, read every RD_LAT+1 cycles.
- No response backpressure: rsp_valid is a fire-and-forget pulse. Requesters hold valid, addr and data stable until ready.
- SRAM_ADDR_Pin and SRAM_DATA_IN_Pin hold their last value when idle. WR_n never falls in a cycle where CS_n is high.

Optional Feature:
- Macro SRAM_ARB_STATS_EN.
- When defined: adds outputs stat_wr (16b), stat_rd (16b) and stat_stall (16b).
  - stat_wr / stat_rd: accepted writes / reads.
  - stat_stall: cycles in which any valid is high and the corresponding ready is low.
  - All counters saturate at 0xFFFF and clear on RST.
- When undefined: the ports are absent and there is no counter logic.

Decomposition:
- Package sram_arb_pkg: state encoding localparams, DIR_READ/DIR_WRITE constants, default ADDRW/DATAW/RD_LAT/TURN.
- Sub-module sram_arb_rr: 2-requester round-robin grant with a last-grant register, updated only on accept.

Test Plan:
- Single write (wr_addr = 0x00123, wr_data = 0xDEADBEEF_...; RD_LAT=2, TURN=1, reset state):
  - wr_ready at T, TURN at T+1 (last_dir = READ), CS_n low T+2..T+4, WR_n low only T+3.
  - mode_R1_W0 = 0 at T+2..T+4, pins show addr/data.
- Read after write (rd_addr = 0x00123, SRAM model returns the stored word):
  - rd_ready at T, TURN at T+1, CS_n/OE_n low T+2..T+3.
  - rsp_valid at T+4 with rsp_data = written word.
- Simultaneous wr_valid & rd_valid held for 20 cycles:
  - Grants alternate W, R, W, R.
  - Every direction change is preceded by exactly 1 TURN cycle; no cycle has both readys high.
- Back-to-back reads (TURN=0, RD_LAT=3): accepts every 4 cycles; rsp_valid 4 cycles after each accept; no TURN state.
- RST asserted in WR_PULSE: WR_n and CS_n go high within the same cycle and no rsp_valid follows; after release, a fresh write completes normally.
- With SRAM_ARB_STATS_EN: 3 writes, 2 reads and 5 contended cycles give stat_wr = 3, stat_rd = 2, stat_stall = 5; forced 70000 stall cycles give stat_stall = 0xFFFF.
